msk_refresh_pipe: RTL and testbench
===================================

// Module: msk_refresh_pipe
// PURPOSE
// - Registered, randomness-fed refresh stage with valid/ready flow control; sits directly upstream of the masked
//   inverter, which copies shares 1..d-1 unchanged and complements share 0 only.
// - Re-randomises each d-share sharing with fresh bits before the affine inverter and downstream non-linear gadgets.
// - Output shares are flop outputs only, so no glitchy XOR combination leaves the block.
// - 2-entry skid buffer: full throughput without a combinational ready path from out_ready to in_ready.
// PARAMETERS
// - d      2  masking order + 1 (shares per sharing); elaboration error if d < 2
// - count  1  number of independent sharings carried in parallel
// PORTS
// - clk        in   1             clock; all state updates on the rising edge
// - rst_n      in   1             asynchronous, active-low reset
// - in_shares  in   count*d       input sharings; share j of sharing i at bit i*d+j
// - in_valid   in   1             in_shares valid
// - in_ready   out  1             stage can accept a sharing this cycle
// - rnd        in   count*(d-1)   fresh randomness; bit i*(d-1)+k masks share k+1 of sharing i
// - rnd_valid  in   1             rnd valid
// - rnd_ready  out  1             rnd consumed this cycle
// - out_shares out  count*d       refreshed sharings; same bit layout as in_shares
// - out_valid  out  1             out_shares valid
// - out_ready  in   1             downstream accepts out_shares
// BEHAVIOUR
// - Refresh for sharing i and k in 0..d-2: r = rnd[i*(d-1)+k].
//   - New share k+1 = share k+1 ^ r.
//   - New share 0 = share 0 ^ XOR of all r for that sharing.
//   - XOR of shares is unchanged (sum-zero refresh).
// - Refresh is computed combinationally and captured into a buffer entry on acceptance.
// - Fire rules (full = 2 entries held; armed_q = flop cleared by reset, set 1 on first clk after release):
//   - in_fire  = in_valid  & in_ready;   in_ready  = armed_q & ~full & rnd_valid
//   - rnd_fire = rnd_valid & rnd_ready;  rnd_ready = armed_q & ~full & in_valid
//   - rnd_fire == in_fire always: randomness is never consumed without data, nor data without randomness.
//   - out_fire = out_valid & out_ready
// - in_ready/rnd_ready depend on valids only, never on out_ready. No combinational in->out data path.
// - FSM on occupancy:
//   - EMPTY: in_fire -> ONE.
//   - ONE: out_valid=1.
//     - in_fire & ~out_fire -> TWO.
//     - out_fire & ~in_fire -> EMPTY.
//     - out_fire & in_fire -> ONE (new entry becomes head).
//   - TWO: out_valid=1, full=1, no accept. out_fire -> ONE (second entry promoted to head).
// - Latency: accepted sharing appears on out_shares the next cycle if the buffer was empty. Strict FIFO order.
// - out_shares holds stable while out_valid & ~out_ready.
// - Reset (asynchronous, any time incl. mid-transfer):
//   - State -> EMPTY; both entries -> 0; armed_q -> 0.
//   - out_valid=0, out_shares=0, in_ready=0, rnd_ready=0.
//   - Buffered sharings are discarded, not drained.
// - Empty buffer entries hold 0, never stale shares.
// STRUCTURE
// - msk_pkg holds:
//   - localparam-style functions: share index (i*d+j) and rnd index (i*(d-1)+k).
//   - FSM state typedef EMPTY/ONE/TWO.
// - Sub-module msk_refresh_core #(d,count): purely combinational sum-zero refresh, annotated for fullverif as a
//   sharing-in/sharing-out gadget with latency 0.
// - msk_refresh_pipe wraps msk_refresh_core with skid buffer, FSM and armed_q.
//   - Top annotations: fv_type sharing, fv_latency=1, fv_count=count on data ports.
// TESTING
// - Reset: assert rst_n=0 with in_valid=1, rnd_valid=1 -> out_valid=0, out_shares=0, in_ready=0, rnd_ready=0;
//   first cycle after release still in_ready=0.
// - Single transfer, d=2, count=1: in_shares=2'b01, rnd=1'b1, out_ready=1 -> next cycle out_valid=1,
//   out_shares=2'b10; unmasked value preserved (XOR=1).
// - Randomness starvation: in_valid=1, rnd_valid=0 for 5 cycles -> in_ready=0, rnd_ready=0, nothing accepted;
//   rnd_valid=1 -> exactly one sharing and one rnd word consumed.
// - Backpressure, d=3, count=2: out_ready=0, push A then B -> TWO, in_ready=0, out_shares stays A.
//   Release out_ready -> A then B in order, each share-XOR equal to input's.
// - Simultaneous push/pop in ONE for 100 cycles with random data/rnd -> one output per cycle, FIFO order,
//   XOR-of-shares equal, rnd_fire count == in_fire count.
// - Mid-operation reset in TWO -> outputs to 0 asynchronously (before next clk edge), both entries dropped,
//   no stale output after release.

Source files
------------

// File: rtl/msk_refresh_pipe_pkg.sv
// Shared types and index helpers for the masked refresh pipeline.
// Share j of sharing i sits at bit i*d+j; randomness bit k of sharing i at i*(d-1)+k.
package msk_refresh_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic int share_idx(input int d, input int i, input int j);
    return i * d + j;
  endfunction

  function automatic int rnd_idx(input int d, input int i, input int k);
    return i * (d - 1) + k;
  endfunction

endpackage

// File: rtl/msk_refresh_pipe_if.sv
// Bus bundle for the refresh pipe: input sharing, fresh randomness, output sharing.
// Handshake: a transfer happens on a rising edge where valid & ready; valid never waits on ready.
interface msk_refresh_pipe_if #(
  parameter int d     = 2,
  parameter int count = 1
);
  import msk_refresh_pipe_pkg::*;

  (* fv_type = "sharing", fv_latency = 1, fv_count = count *)
  logic [count*d-1:0]     in_shares;
  logic                   in_valid;
  logic                   in_ready;
  (* fv_type = "random", fv_count = 1 *)
  logic [count*(d-1)-1:0] rnd;
  logic                   rnd_valid;
  logic                   rnd_ready;
  (* fv_type = "sharing", fv_latency = 1, fv_count = count *)
  logic [count*d-1:0]     out_shares;
  logic                   out_valid;
  logic                   out_ready;
  state_t                 state;

  modport master (
    output in_shares, in_valid, rnd, rnd_valid, out_ready,
    input  in_ready, rnd_ready, out_shares, out_valid, state
  );

  modport slave (
    input  in_shares, in_valid, rnd, rnd_valid, out_ready,
    output in_ready, rnd_ready, out_shares, out_valid, state
  );

endinterface

// File: rtl/msk_refresh_core.sv
// Combinational sum-zero refresh: each fresh bit masks share k+1 and is folded into share 0,
// so the XOR of every sharing is unchanged.
module msk_refresh_core
  import msk_refresh_pipe_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 1
) (
  (* fv_type = "sharing", fv_latency = 0, fv_count = count *)
  input  logic [count*d-1:0]     in_shares,
  (* fv_type = "random", fv_count = 1 *)
  input  logic [count*(d-1)-1:0] rnd,
  (* fv_type = "sharing", fv_latency = 0, fv_count = count *)
  output logic [count*d-1:0]     out_shares
);

  if (d < 2) begin : g_bad_d
    $error("msk_refresh_core: d must be at least 2");
  end

  always_comb begin
    out_shares = in_shares;
    for (int i = 0; i < count; i++) begin
      for (int k = 0; k < d - 1; k++) begin
        out_shares[share_idx(d, i, k + 1)] = out_shares[share_idx(d, i, k + 1)] ^ rnd[rnd_idx(d, i, k)];
        out_shares[share_idx(d, i, 0)]     = out_shares[share_idx(d, i, 0)] ^ rnd[rnd_idx(d, i, k)];
      end
    end
  end

endmodule

// File: rtl/msk_refresh_pipe.sv
// Registered refresh stage: refresh is captured into a 2-entry buffer whose head entry drives
// out_shares straight from flops; ready never depends on out_ready.
module msk_refresh_pipe
  import msk_refresh_pipe_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  msk_refresh_pipe_if.slave   bus
);

  localparam int W = count * d;

  state_t         state_q, state_d;
  logic [W-1:0]   fresh;
  logic [W-1:0]   e0_q, e1_q, e0_d, e1_d;
  logic           armed_q;
  logic           full;
  logic           accept_ok;
  logic           in_fire;
  logic           out_fire;

  msk_refresh_core #(.d(d), .count(count)) u_core (
    .in_shares  (bus.in_shares),
    .rnd        (bus.rnd),
    .out_shares (fresh)
  );

  // Data and randomness are accepted together or not at all, so neither is ever wasted.
  assign full          = (state_q == TWO);
  assign accept_ok     = armed_q & ~full;
  assign bus.in_ready  = accept_ok & bus.rnd_valid;
  assign bus.rnd_ready = accept_ok & bus.in_valid;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_shares = e0_q;
  assign bus.state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      armed_q <= 1'b1;
    end
  end

  // Vacated entries are zeroed so no stale shares linger in the buffer.
  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          e0_d    = fresh;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            e1_d    = fresh;
            state_d = TWO;
          end
          2'b01: begin
            e0_d    = '0;
            state_d = EMPTY;
          end
          2'b11: begin
            e0_d    = fresh;
            state_d = ONE;
          end
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        if (out_fire) begin
          e0_d    = e1_q;
          e1_d    = '0;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
        e0_d    = '0;
        e1_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_msk_refresh_pipe.sv
// Bench for msk_refresh_pipe: a d=2/count=1 instance for the basic transfer and a d=3/count=2
// instance checked cycle by cycle against a queue-based reference model.
module tb_msk_refresh_pipe;
  import msk_refresh_pipe_pkg::*;

  localparam int DA = 2;
  localparam int CA = 1;
  localparam int DB = 3;
  localparam int CB = 2;
  localparam int WB = CB * DB;
  localparam int RB = CB * (DB - 1);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  msk_refresh_pipe_if #(.d(DA), .count(CA)) ifa ();
  msk_refresh_pipe_if #(.d(DB), .count(CB)) ifb ();

  msk_refresh_pipe #(.d(DA), .count(CA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  msk_refresh_pipe #(.d(DB), .count(CB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  logic [WB-1:0] exp_q[$];
  logic [CB-1:0] sec_q[$];
  bit            armed_m;
  int            n_in, n_rnd, n_out;

  // Reference refresh straight from the rule: share k+1 ^= r_k, share 0 ^= XOR of all r_k.
  function automatic logic [WB-1:0] ref_refresh(input logic [WB-1:0] s, input logic [RB-1:0] r);
    logic [WB-1:0] o;
    logic          par;
    o = s;
    for (int i = 0; i < CB; i++) begin
      par = 1'b0;
      for (int k = 0; k < DB - 1; k++) begin
        o[i*DB + k + 1] = s[i*DB + k + 1] ^ r[i*(DB-1) + k];
        par             = par ^ r[i*(DB-1) + k];
      end
      o[i*DB] = s[i*DB] ^ par;
    end
    return o;
  endfunction

  function automatic logic [CB-1:0] secrets(input logic [WB-1:0] s);
    logic [CB-1:0] x;
    x = '0;
    for (int i = 0; i < CB; i++)
      for (int j = 0; j < DB; j++)
        x[i] = x[i] ^ s[i*DB + j];
    return x;
  endfunction

  task automatic rand_b_data();
    ifb.in_shares = WB'($urandom);
    ifb.rnd       = RB'($urandom);
  endtask

  // One clock of instance B: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle_b();
    logic [WB-1:0] exp_out;
    logic          exp_ov, exp_ir, exp_rr;
    bit            ifire, ofire;
    @(negedge clk);
    exp_ov  = (exp_q.size() != 0);
    exp_out = exp_ov ? exp_q[0] : '0;
    exp_ir  = armed_m && (exp_q.size() < 2) && ifb.rnd_valid;
    exp_rr  = armed_m && (exp_q.size() < 2) && ifb.in_valid;
    checks++;
    if (ifb.out_valid !== exp_ov) begin
      errors++; $display("FAIL b_out_valid: got %b expected %b at %0t", ifb.out_valid, exp_ov, $time);
    end
    checks++;
    if (ifb.out_shares !== exp_out) begin
      errors++; $display("FAIL b_out_shares: got %h expected %h at %0t", ifb.out_shares, exp_out, $time);
    end
    checks++;
    if (ifb.in_ready !== exp_ir) begin
      errors++; $display("FAIL b_in_ready: got %b expected %b at %0t", ifb.in_ready, exp_ir, $time);
    end
    checks++;
    if (ifb.rnd_ready !== exp_rr) begin
      errors++; $display("FAIL b_rnd_ready: got %b expected %b at %0t", ifb.rnd_ready, exp_rr, $time);
    end
    if (exp_ov) begin
      checks++;
      if (secrets(ifb.out_shares) !== sec_q[0]) begin
        errors++; $display("FAIL b_secret: got %h expected %h at %0t", secrets(ifb.out_shares), sec_q[0], $time);
      end
    end
    if (ifb.in_valid && ifb.in_ready)   n_in++;
    if (ifb.rnd_valid && ifb.rnd_ready) n_rnd++;
    if (ifb.out_valid && ifb.out_ready) n_out++;
    ifire = ifb.in_valid && exp_ir;
    ofire = exp_ov && ifb.out_ready;
    @(posedge clk);
    if (ofire) begin
      void'(exp_q.pop_front());
      void'(sec_q.pop_front());
    end
    if (ifire) begin
      exp_q.push_back(ref_refresh(ifb.in_shares, ifb.rnd));
      sec_q.push_back(secrets(ifb.in_shares));
    end
    armed_m = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.in_valid = 1'b1; ifa.rnd_valid = 1'b1; ifa.out_ready = 1'b1;
    ifa.in_shares = 2'b11; ifa.rnd = 1'b1;
    ifb.in_valid = 1'b1; ifb.rnd_valid = 1'b1; ifb.out_ready = 1'b1;
    rand_b_data();
    armed_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifa.out_valid, ifa.in_ready, ifa.rnd_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_a_flags: got %b expected 000", {ifa.out_valid, ifa.in_ready, ifa.rnd_ready});
    end
    checks++;
    if (ifa.out_shares !== 2'b00) begin
      errors++; $display("FAIL reset_a_shares: got %h expected 0", ifa.out_shares);
    end
    checks++;
    if ({ifb.out_valid, ifb.in_ready, ifb.rnd_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_b_flags: got %b expected 000", {ifb.out_valid, ifb.in_ready, ifb.rnd_ready});
    end
    checks++;
    if (ifb.out_shares !== '0) begin
      errors++; $display("FAIL reset_b_shares: got %h expected 0", ifb.out_shares);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({ifa.in_ready, ifa.rnd_ready, ifb.in_ready, ifb.rnd_ready} !== 4'b0000) begin
      errors++; $display("FAIL release_not_armed: got %b expected 0000",
                         {ifa.in_ready, ifa.rnd_ready, ifb.in_ready, ifb.rnd_ready});
    end
    ifa.in_valid = 1'b0; ifa.rnd_valid = 1'b0;
    ifb.in_valid = 1'b0; ifb.rnd_valid = 1'b0;
    @(posedge clk);
    armed_m = 1'b1;
    #1;
  endtask

  task automatic test_single_transfer();
    ifa.in_shares = 2'b01; ifa.rnd = 1'b1;
    ifa.in_valid = 1'b1; ifa.rnd_valid = 1'b1; ifa.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifa.in_ready, ifa.rnd_ready} !== 2'b11) begin
      errors++; $display("FAIL single_ready: got %b expected 11", {ifa.in_ready, ifa.rnd_ready});
    end
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0; ifa.rnd_valid = 1'b0;
    checks++;
    if (ifa.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid: got %b expected 1", ifa.out_valid);
    end
    checks++;
    if (ifa.out_shares !== 2'b10) begin
      errors++; $display("FAIL single_shares: got %b expected 10", ifa.out_shares);
    end
    checks++;
    if ((^ifa.out_shares) !== 1'b1) begin
      errors++; $display("FAIL single_secret: got %b expected 1", ^ifa.out_shares);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({ifa.out_valid, ifa.out_shares} !== 3'b000) begin
      errors++; $display("FAIL single_drained: got %b expected 000", {ifa.out_valid, ifa.out_shares});
    end
  endtask

  task automatic test_rnd_starvation();
    int i0, r0;
    i0 = n_in; r0 = n_rnd;
    rand_b_data();
    ifb.in_valid = 1'b1; ifb.rnd_valid = 1'b0; ifb.out_ready = 1'b1;
    repeat (5) cycle_b();
    checks++;
    if ((n_in - i0) !== 0 || (n_rnd - r0) !== 0) begin
      errors++; $display("FAIL starve_none: got in=%0d rnd=%0d expected 0 0", n_in - i0, n_rnd - r0);
    end
    ifb.rnd_valid = 1'b1;
    cycle_b();
    ifb.in_valid = 1'b0; ifb.rnd_valid = 1'b0;
    repeat (2) cycle_b();
    checks++;
    if ((n_in - i0) !== 1 || (n_rnd - r0) !== 1) begin
      errors++; $display("FAIL starve_one: got in=%0d rnd=%0d expected 1 1", n_in - i0, n_rnd - r0);
    end
  endtask

  task automatic test_backpressure();
    logic [WB-1:0] a_exp;
    int            o0;
    o0 = n_out;
    ifb.out_ready = 1'b0;
    ifb.in_valid = 1'b1; ifb.rnd_valid = 1'b1;
    rand_b_data();
    cycle_b();
    a_exp = exp_q[0];
    rand_b_data();
    cycle_b();
    rand_b_data();
    cycle_b();
    checks++;
    if (ifb.state !== TWO) begin
      errors++; $display("FAIL bp_state: got %0d expected %0d", ifb.state, TWO);
    end
    checks++;
    if (ifb.out_shares !== a_exp) begin
      errors++; $display("FAIL bp_head_hold: got %h expected %h", ifb.out_shares, a_exp);
    end
    ifb.in_valid = 1'b0; ifb.rnd_valid = 1'b0;
    repeat (2) cycle_b();
    ifb.out_ready = 1'b1;
    repeat (3) cycle_b();
    checks++;
    if ((n_out - o0) !== 2) begin
      errors++; $display("FAIL bp_drain_count: got %0d expected 2", n_out - o0);
    end
  endtask

  task automatic test_back_to_back();
    int i0, r0, o0;
    i0 = n_in; r0 = n_rnd; o0 = n_out;
    ifb.out_ready = 1'b1; ifb.in_valid = 1'b1; ifb.rnd_valid = 1'b1;
    for (int c = 0; c < 101; c++) begin
      rand_b_data();
      cycle_b();
    end
    ifb.in_valid = 1'b0; ifb.rnd_valid = 1'b0;
    repeat (2) cycle_b();
    checks++;
    if ((n_in - i0) !== 101 || (n_out - o0) !== 101) begin
      errors++; $display("FAIL b2b_throughput: got in=%0d out=%0d expected 101 101", n_in - i0, n_out - o0);
    end
    checks++;
    if ((n_rnd - r0) !== (n_in - i0)) begin
      errors++; $display("FAIL b2b_rnd_count: got %0d expected %0d", n_rnd - r0, n_in - i0);
    end
  endtask

  task automatic test_random_flow();
    int i0, r0, o0;
    i0 = n_in; r0 = n_rnd; o0 = n_out;
    for (int c = 0; c < 150; c++) begin
      rand_b_data();
      ifb.in_valid  = ($urandom_range(0, 3) != 0);
      ifb.rnd_valid = ($urandom_range(0, 3) != 0);
      ifb.out_ready = ($urandom_range(0, 2) != 0);
      cycle_b();
    end
    ifb.in_valid = 1'b0; ifb.rnd_valid = 1'b0; ifb.out_ready = 1'b1;
    repeat (3) cycle_b();
    checks++;
    if ((n_rnd - r0) !== (n_in - i0) || (n_out - o0) !== (n_in - i0)) begin
      errors++; $display("FAIL rand_counts: got in=%0d rnd=%0d out=%0d expected all equal",
                         n_in - i0, n_rnd - r0, n_out - o0);
    end
  endtask

  task automatic test_mid_reset();
    ifb.out_ready = 1'b0; ifb.in_valid = 1'b1; ifb.rnd_valid = 1'b1;
    rand_b_data();
    cycle_b();
    rand_b_data();
    cycle_b();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifb.out_valid, ifb.in_ready, ifb.rnd_ready} !== 3'b000) begin
      errors++; $display("FAIL midrst_flags: got %b expected 000", {ifb.out_valid, ifb.in_ready, ifb.rnd_ready});
    end
    checks++;
    if (ifb.out_shares !== '0 || ifb.state !== EMPTY) begin
      errors++; $display("FAIL midrst_clear: got shares=%h state=%0d expected 0 0", ifb.out_shares, ifb.state);
    end
    exp_q.delete();
    sec_q.delete();
    armed_m = 1'b0;
    ifb.in_valid = 1'b0; ifb.rnd_valid = 1'b0; ifb.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    armed_m = 1'b1;
    #1;
    repeat (3) cycle_b();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    n_in = 0; n_rnd = 0; n_out = 0;
    test_reset();
    test_single_transfer();
    test_rnd_starvation();
    test_backpressure();
    test_back_to_back();
    test_random_flow();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
